// File: rtl/seq_gen_1011.sv
// seq_gen_1011: serial pattern transmitter.
// On an accepted start it shifts PATTERN out MSB first, one bit per clock,
// repeats it rpt times with gap idle bit-times between repetitions, and
// closes the transfer with a one-cycle done pulse. All outputs are registered
// and are computed alongside the next state, so each output is valid during
// the cycle its state is active.
module seq_gen_1011 #(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
  parameter int                CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] rpt,
  input  logic [CNT_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;      // bit of PATTERN currently on out
  logic [CNT_W-1:0] rem_reg;      // repetitions still to finish, incl. current
  logic [CNT_W-1:0] gap_cnt_reg;  // idle cycles left in the current gap
  logic [CNT_W-1:0] gap_lat_reg;  // gap length captured with start

  logic [IDX_W-1:0] idx_dec;

  // Next index while walking down the pattern within one repetition.
  assign idx_dec = idx_reg - 1'b1;

  // Transfer FSM with registered outputs; counters only ever count down to 1,
  // so full-scale rpt/gap values never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      rem_reg     <= '0;
      gap_cnt_reg <= '0;
      gap_lat_reg <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            if (rpt != '0) begin
              state_reg   <= SEND;
              rem_reg     <= rpt;
              gap_lat_reg <= gap;
              idx_reg     <= IDX_TOP;
              out         <= PATTERN[IDX_TOP];
              out_valid   <= 1'b1;
              busy        <= 1'b1;
            end else begin
              // Zero repetitions: report completion without sending anything.
              state_reg <= DONE;
              done      <= 1'b1;
            end
          end
        end

        SEND: begin
          if (idx_reg != '0) begin
            idx_reg   <= idx_dec;
            out       <= PATTERN[idx_dec];
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end else begin
            // Last bit of this repetition is on out now.
            rem_reg <= rem_reg - CNT_ONE;
            if (rem_reg == CNT_ONE) begin
              state_reg <= DONE;
              out       <= 1'b0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (gap_lat_reg == '0) begin
              // Back-to-back repetition, no bubble.
              idx_reg   <= IDX_TOP;
              out       <= PATTERN[IDX_TOP];
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end else begin
              state_reg   <= GAP;
              gap_cnt_reg <= gap_lat_reg;
              out         <= 1'b0;
              out_valid   <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end

        GAP: begin
          if (gap_cnt_reg == CNT_ONE) begin
            state_reg <= SEND;
            idx_reg   <= IDX_TOP;
            out       <= PATTERN[IDX_TOP];
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - CNT_ONE;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_1011.sv
// tb_seq_gen_1011: bench for the serial 1011 pattern transmitter.
// A per-transfer reference builds the expected cycle-by-cycle output queue
// from the transfer rules; a table of transfers checks lengths and done
// timing, and hand sequences cover reset and ignored-start corner cases.
module tb_seq_gen_1011;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] rpt   = 4'd0;
  logic [3:0] gap   = 4'd0;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  seq_gen_1011 #(
    .PAT_W  (4),
    .PATTERN(4'b1011),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rpt      (rpt),
    .gap      (gap),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [3:0] rpt;
    logic [3:0] gap;
    int         exp_busy;
    int         exp_valid;
    int         exp_done_off;
  } vec_t;

  vec_t        vecs[6];
  logic [3:0]  pat_model = 4'b1011;
  logic [3:0]  q[$];          // expected {out,out_valid,busy,done} per cycle
  bit          idle_now;
  int          total  = 0;
  int          passed = 0;
  logic [3:0]  obs;
  logic [31:0] stream;
  int          nvalid;
  logic [3:0]  sh;
  int          match_cnt;
  int          busy_cnt;
  int          valid_cnt;
  int          done_off;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Expected output stream of one accepted transfer.
  task automatic build(input int r, input int g);
    if (r == 0) begin
      q.push_back(4'b0001);
    end else begin
      for (int i = 0; i < r; i++) begin
        for (int b = 3; b >= 0; b--) q.push_back({pat_model[b], 1'b1, 1'b1, 1'b0});
        if (i < r - 1) for (int k = 0; k < g; k++) q.push_back(4'b0010);
      end
      q.push_back(4'b0001);
    end
  endtask

  // Drive inputs for the current cycle, then check the following cycle.
  task automatic cycle(input logic s, input logic [3:0] r, input logic [3:0] g);
    logic [3:0] exp;
    start = s;
    rpt   = r;
    gap   = g;
    if (idle_now && s) build(int'(r), int'(g));
    @(posedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      exp      = q.pop_front();
      idle_now = 1'b0;
    end else begin
      exp      = 4'b0000;
      idle_now = 1'b1;
    end
    obs = {out, out_valid, busy, done};
    if (out_valid) begin
      stream = {stream[30:0], out};
      sh     = {sh[2:0], out};
      nvalid++;
      if (nvalid >= 4 && sh == 4'b1011) match_cnt++;
    end
    chk("cycle_outputs", {28'd0, obs}, {28'd0, exp});
  endtask

  // One transfer from acceptance to the cycle after done; with hold set,
  // start is re-asserted with junk rpt/gap throughout SEND, GAP and DONE.
  task automatic run_transfer(input logic [3:0] r, input logic [3:0] g, input bit hold);
    busy_cnt  = 0;
    valid_cnt = 0;
    done_off  = 0;
    stream    = 0;
    nvalid    = 0;
    sh        = 0;
    match_cnt = 0;
    for (int off = 1; off <= 400 && done_off == 0; off++) begin
      if (off == 1) cycle(1'b1, r, g);
      else cycle(hold, 4'($urandom), 4'($urandom));
      if (obs[1]) busy_cnt++;
      if (obs[2]) valid_cnt++;
      if (obs[0]) done_off = off;
    end
    if (done_off == 0) chk("done_timeout", 32'd0, 32'd1);
    cycle(hold, 4'($urandom), 4'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'd1,  4'd0,  4,   4,  5};
    vecs[1] = '{4'd3,  4'd2,  16,  12, 17};
    vecs[2] = '{4'd2,  4'd0,  8,   8,  9};
    vecs[3] = '{4'd15, 4'd15, 270, 60, 271};
    vecs[4] = '{4'd0,  4'd5,  0,   0,  1};
    vecs[5] = '{4'd1,  4'd15, 4,   4,  5};

    // Reset held with start asserted: everything stays 0.
    start = 1'b1;
    rpt   = 4'd1;
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", {28'd0, out, out_valid, busy, done}, 32'd0);
    end
    start = 1'b0;
    reset = 1'b1;
    q.delete();
    idle_now = 1'b1;
    repeat (3) cycle(1'b0, 4'd0, 4'd0);

    // Single repetition: exact bit stream and done timing.
    run_transfer(4'd1, 4'd0, 1'b0);
    chk("single_stream", stream, 32'b1011);
    chk("single_done_off", done_off, 5);

    // Back-to-back repetitions: continuous valid, two matcher hits.
    run_transfer(4'd2, 4'd0, 1'b0);
    chk("b2b_stream", stream, 32'b10111011);
    chk("b2b_valid", valid_cnt, 8);
    chk("b2b_matches", match_cnt, 2);

    // Table of transfers: busy length, valid bits and done offset.
    for (int i = 0; i < 6; i++) begin
      run_transfer(vecs[i].rpt, vecs[i].gap, 1'b0);
      chk($sformatf("tbl%0d_busy", i), busy_cnt, vecs[i].exp_busy);
      chk($sformatf("tbl%0d_valid", i), valid_cnt, vecs[i].exp_valid);
      chk($sformatf("tbl%0d_done", i), done_off, vecs[i].exp_done_off);
    end

    // start pulsed in SEND, GAP and DONE has no effect.
    run_transfer(4'd3, 4'd2, 1'b1);
    chk("ign_busy", busy_cnt, 16);
    chk("ign_valid", valid_cnt, 12);
    chk("ign_done", done_off, 17);
    run_transfer(4'd0, 4'd0, 1'b1);
    chk("ign_zero_done", done_off, 1);
    chk("ign_zero_busy", busy_cnt, 0);

    // Reset asserted during the third bit of a rpt=2 gap=1 transfer.
    cycle(1'b1, 4'd2, 4'd1);
    cycle(1'b0, 4'd0, 4'd0);
    cycle(1'b0, 4'd0, 4'd0);
    chk("mid_third_bit", {28'd0, obs}, 32'b1110);
    #2 reset = 1'b0;
    #1 chk("mid_async_clear", {28'd0, out, out_valid, busy, done}, 32'd0);
    q.delete();
    idle_now = 1'b1;
    start = 1'b1;
    rpt   = 4'd3;
    repeat (2) begin
      @(negedge clk);
      chk("mid_reset_hold", {28'd0, out, out_valid, busy, done}, 32'd0);
    end
    start = 1'b0;
    reset = 1'b1;
    run_transfer(4'd1, 4'd0, 1'b0);
    chk("post_reset_stream", stream, 32'b1011);
    chk("post_reset_done", done_off, 5);

    // Randomized traffic against the reference queue.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom % 4) == 0, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 3)));
    end

    start = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
